// File: rtl/multi_chan_fifo_if.sv
// Handshake bundle for multi_chan_fifo: tagged write port, channel-addressed read port,
// and per-channel full/empty status.
interface multi_chan_fifo_if #(
  parameter type data_t   = logic [7:0],
  parameter int  CHAN_NUM = 4
);
  localparam int CHAN_W = (CHAN_NUM > 1) ? $clog2(CHAN_NUM) : 1;

  logic              w_valid_i;
  logic [CHAN_W-1:0] w_chan_i;
  data_t             w_data_i;
  logic              w_ready_o;

  logic              r_req_i;
  logic [CHAN_W-1:0] r_chan_i;
  logic              r_valid_o;
  data_t             r_data_o;
  logic [CHAN_W-1:0] r_chan_o;

  logic [CHAN_NUM-1:0] full_o;
  logic [CHAN_NUM-1:0] empty_o;

  modport slave (
    input  w_valid_i, w_chan_i, w_data_i, r_req_i, r_chan_i,
    output w_ready_o, r_valid_o, r_data_o, r_chan_o, full_o, empty_o
  );

  modport master (
    output w_valid_i, w_chan_i, w_data_i, r_req_i, r_chan_i,
    input  w_ready_o, r_valid_o, r_data_o, r_chan_o, full_o, empty_o
  );
endinterface

// File: rtl/multi_chan_fifo.sv
// Shared-memory FIFO split into CHAN_NUM circular queues with a registered read port.
// Define MULTI_CHAN_FIFO_FLUSH_EN to add the per-channel flush_i input.
module multi_chan_fifo #(
  parameter type data_t          = logic [7:0],
  parameter int  CHAN_NUM        = 4,
  parameter int  CHAN_ADDR_WIDTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
`ifdef MULTI_CHAN_FIFO_FLUSH_EN
  input  logic [CHAN_NUM-1:0] flush_i,
`endif
  multi_chan_fifo_if.slave    bus
);
  localparam int CHAN_W    = (CHAN_NUM > 1) ? $clog2(CHAN_NUM) : 1;
  localparam int DEPTH     = 1 << CHAN_ADDR_WIDTH;
  localparam int CHAN_SPAN = 1 << CHAN_W;
  localparam int ADDR_W    = CHAN_W + CHAN_ADDR_WIDTH;

  typedef logic [CHAN_ADDR_WIDTH:0] ptr_t;

  ptr_t              wp_q [CHAN_NUM];
  ptr_t              wp_d [CHAN_NUM];
  ptr_t              rp_q [CHAN_NUM];
  ptr_t              rp_d [CHAN_NUM];
  data_t             mem_q [CHAN_NUM*DEPTH];
  data_t             r_data_q;
  logic [CHAN_W-1:0] r_chan_q;
  logic              r_valid_q;

  logic [CHAN_NUM-1:0]  full, empty;
  logic [CHAN_SPAN-1:0] chan_ok, full_ext, empty_ext, flush_ext;
  logic                 w_acc, r_acc;
  logic [ADDR_W-1:0]    w_addr, r_addr;

  // Flags look only at registered pointers, never at this cycle's requests.
  always_comb begin
    for (int c = 0; c < CHAN_NUM; c++) begin
      empty[c] = (wp_q[c] == rp_q[c]);
      full[c]  = (wp_q[c][CHAN_ADDR_WIDTH] != rp_q[c][CHAN_ADDR_WIDTH]) &&
                 (wp_q[c][CHAN_ADDR_WIDTH-1:0] == rp_q[c][CHAN_ADDR_WIDTH-1:0]);
    end
  end

  // Channel-indexed lookups padded to the full index range; unused indices read as
  // invalid, full and empty so out-of-range requests are always refused.
  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    chan_ok   = '0;
    full_ext  = '1;
    empty_ext = '1;
    flush_ext = '0;
    for (int c = 0; c < CHAN_NUM; c++) begin
      chan_ok[c]   = 1'b1;
      full_ext[c]  = full[c];
      empty_ext[c] = empty[c];
`ifdef MULTI_CHAN_FIFO_FLUSH_EN
      flush_ext[c] = flush_i[c];
`endif
    end
  end

  assign bus.w_ready_o = chan_ok[bus.w_chan_i] && !full_ext[bus.w_chan_i] &&
                         !flush_ext[bus.w_chan_i];
  assign w_acc = bus.w_valid_i && bus.w_ready_o;
  assign r_acc = bus.r_req_i && chan_ok[bus.r_chan_i] && !empty_ext[bus.r_chan_i] &&
                 !flush_ext[bus.r_chan_i];

  assign w_addr = {bus.w_chan_i, wp_q[bus.w_chan_i][CHAN_ADDR_WIDTH-1:0]};
  assign r_addr = {bus.r_chan_i, rp_q[bus.r_chan_i][CHAN_ADDR_WIDTH-1:0]};

  // NOTE: blocking assignments here describe combinational next state; the flops below use <=.
  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (w_acc) wp_d[bus.w_chan_i] = wp_q[bus.w_chan_i] + 1'b1;
    if (r_acc) rp_d[bus.r_chan_i] = rp_q[bus.r_chan_i] + 1'b1;
    for (int c = 0; c < CHAN_NUM; c++) begin
      if (flush_ext[c]) rp_d[c] = wp_q[c];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int c = 0; c < CHAN_NUM; c++) begin
        wp_q[c] <= '0;
        rp_q[c] <= '0;
      end
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_chan_q  <= '0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      r_valid_q <= r_acc;
      if (r_acc) begin
        r_data_q <= mem_q[r_addr];
        r_chan_q <= bus.r_chan_i;
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (w_acc) mem_q[w_addr] <= bus.w_data_i;
  end

  assign bus.r_valid_o = r_valid_q;
  assign bus.r_data_o  = r_data_q;
  assign bus.r_chan_o  = r_chan_q;
  assign bus.full_o    = full;
  assign bus.empty_o   = empty;
endmodule

// File: tb/tb_multi_chan_fifo.sv
// Randomised bench for multi_chan_fifo, checked against per-channel queue models.
module tb_multi_chan_fifo;
  localparam int CHAN_NUM = 4;
  localparam int AW       = 4;
  localparam int DEPTH    = 16;
  typedef logic [7:0] word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef MULTI_CHAN_FIFO_FLUSH_EN
  logic [CHAN_NUM-1:0] flush = '0;
`endif

  int tests = 0;
  int fails = 0;

  word_t      model_q [CHAN_NUM][$];
  word_t      last_data;
  logic [1:0] last_chan;

  multi_chan_fifo_if #(.data_t(word_t), .CHAN_NUM(CHAN_NUM)) bus ();

  multi_chan_fifo #(
    .data_t(word_t), .CHAN_NUM(CHAN_NUM), .CHAN_ADDR_WIDTH(AW)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
`ifdef MULTI_CHAN_FIFO_FLUSH_EN
    .flush_i(flush),
`endif
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock with the given requests; model decides acceptance from queue occupancy.
  task automatic run_cycle(input logic wv, input logic [1:0] wc, input word_t wd,
                           input logic rq, input logic [1:0] rc, input logic [3:0] fl);
    logic exp_ready, exp_wr, exp_rd;
    logic [3:0] exp_empty, exp_full;
    bus.w_valid_i = wv;
    bus.w_chan_i  = wc;
    bus.w_data_i  = wd;
    bus.r_req_i   = rq;
    bus.r_chan_i  = rc;
`ifdef MULTI_CHAN_FIFO_FLUSH_EN
    flush = fl;
`endif
    exp_ready = (model_q[wc].size() < DEPTH) && !fl[wc];
    exp_wr    = wv && exp_ready;
    exp_rd    = rq && (model_q[rc].size() != 0) && !fl[rc];
    #1;
    tests++;
    if (bus.w_ready_o !== exp_ready) begin
      fails++;
      $display("FAIL w_ready ch%0d: got %b expected %b", wc, bus.w_ready_o, exp_ready);
    end
    @(posedge clk);
    if (exp_rd) begin
      last_data = model_q[rc].pop_front();
      last_chan = rc;
    end
    for (int c = 0; c < CHAN_NUM; c++) if (fl[c]) model_q[c].delete();
    if (exp_wr) model_q[wc].push_back(wd);
    for (int c = 0; c < CHAN_NUM; c++) begin
      exp_empty[c] = (model_q[c].size() == 0);
      exp_full[c]  = (model_q[c].size() == DEPTH);
    end
    #1;
    tests++;
    if (bus.r_valid_o !== exp_rd) begin
      fails++;
      $display("FAIL r_valid: got %b expected %b", bus.r_valid_o, exp_rd);
    end
    tests++;
    if (bus.r_data_o !== last_data || bus.r_chan_o !== last_chan) begin
      fails++;
      $display("FAIL r_data/r_chan: got %h/%0d expected %h/%0d",
               bus.r_data_o, bus.r_chan_o, last_data, last_chan);
    end
    tests++;
    if (bus.empty_o !== exp_empty || bus.full_o !== exp_full) begin
      fails++;
      $display("FAIL flags: got empty %b full %b expected empty %b full %b",
               bus.empty_o, bus.full_o, exp_empty, exp_full);
    end
  endtask

  task automatic idle_cycle();
    run_cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 4'b0000);
  endtask

  // Reset with live requests on the bus; reset must win.
  task automatic apply_reset();
    bus.w_valid_i = 1'b1;
    bus.w_chan_i  = 2'd1;
    bus.w_data_i  = 8'h5A;
    bus.r_req_i   = 1'b1;
    bus.r_chan_i  = 2'd1;
`ifdef MULTI_CHAN_FIFO_FLUSH_EN
    flush = '0;
`endif
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < CHAN_NUM; c++) model_q[c].delete();
    last_data = '0;
    last_chan = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if (bus.empty_o !== 4'b1111) begin
      fails++; $display("FAIL reset empty_o: got %b expected 1111", bus.empty_o);
    end
    tests++;
    if (bus.full_o !== 4'b0000) begin
      fails++; $display("FAIL reset full_o: got %b expected 0000", bus.full_o);
    end
    tests++;
    if (bus.r_valid_o !== 1'b0 || bus.r_data_o !== 8'h00 || bus.r_chan_o !== 2'd0) begin
      fails++;
      $display("FAIL reset read port: got %b/%h/%0d expected 0/00/0",
               bus.r_valid_o, bus.r_data_o, bus.r_chan_o);
    end
    idle_cycle();
  endtask

  task automatic test_basic();
    apply_reset();
    run_cycle(1'b1, 2'd2, 8'h11, 1'b0, 2'd0, 4'b0);
    run_cycle(1'b1, 2'd2, 8'h22, 1'b0, 2'd0, 4'b0);
    run_cycle(1'b1, 2'd2, 8'h33, 1'b0, 2'd0, 4'b0);
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 4'b0);
      tests++;
      if (bus.r_data_o !== 8'h11 * (i + 1) || bus.r_chan_o !== 2'd2) begin
        fails++;
        $display("FAIL basic read %0d: got %h/%0d expected %h/2",
                 i, bus.r_data_o, bus.r_chan_o, 8'(8'h11 * (i + 1)));
      end
    end
    tests++;
    if (bus.empty_o[2] !== 1'b1) begin
      fails++; $display("FAIL basic empty ch2: got %b expected 1", bus.empty_o[2]);
    end
    run_cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 4'b0);
  endtask

  task automatic test_fill();
    apply_reset();
    for (int i = 0; i < DEPTH; i++)
      run_cycle(1'b1, 2'd1, word_t'($urandom), 1'b0, 2'd0, 4'b0);
    tests++;
    if (bus.full_o[1] !== 1'b1) begin
      fails++; $display("FAIL fill full ch1: got %b expected 1", bus.full_o[1]);
    end
    run_cycle(1'b1, 2'd1, 8'hEE, 1'b0, 2'd0, 4'b0);
    run_cycle(1'b1, 2'd0, 8'h77, 1'b0, 2'd0, 4'b0);
    for (int i = 0; i < DEPTH; i++)
      run_cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 4'b0);
    run_cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 4'b0);
    tests++;
    if (bus.r_data_o !== 8'h77) begin
      fails++; $display("FAIL fill ch0 word: got %h expected 77", bus.r_data_o);
    end
  endtask

  task automatic test_full_rw();
    word_t oldest;
    apply_reset();
    oldest = word_t'($urandom);
    run_cycle(1'b1, 2'd3, oldest, 1'b0, 2'd0, 4'b0);
    for (int i = 1; i < DEPTH; i++)
      run_cycle(1'b1, 2'd3, word_t'($urandom), 1'b0, 2'd0, 4'b0);
    run_cycle(1'b1, 2'd3, 8'hC3, 1'b1, 2'd3, 4'b0);
    tests++;
    if (bus.r_data_o !== oldest || bus.full_o[3] !== 1'b0) begin
      fails++;
      $display("FAIL full_rw: got data %h full %b expected %h 0", bus.r_data_o, bus.full_o[3], oldest);
    end
    for (int i = 0; i < DEPTH; i++)
      run_cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 4'b0);
  endtask

  task automatic test_wrap();
    apply_reset();
    run_cycle(1'b1, 2'd0, word_t'($urandom), 1'b0, 2'd0, 4'b0);
    for (int i = 0; i < 40; i++)
      run_cycle(1'b1, 2'd0, word_t'($urandom), 1'b1, 2'd0, 4'b0);
    tests++;
    if (bus.empty_o[0] !== 1'b0 || bus.full_o[0] !== 1'b0) begin
      fails++;
      $display("FAIL wrap flags ch0: got empty %b full %b expected 0 0", bus.empty_o[0], bus.full_o[0]);
    end
    run_cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 4'b0);
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if (i < 300)
        run_cycle($urandom_range(0, 3) != 0, 2'($urandom), word_t'($urandom),
                  $urandom_range(0, 2) == 0, 2'($urandom), 4'b0);
      else
        run_cycle($urandom_range(0, 2) == 0, 2'($urandom), word_t'($urandom),
                  $urandom_range(0, 3) != 0, 2'($urandom), 4'b0);
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    for (int i = 0; i < 3; i++)
      run_cycle(1'b1, 2'd1, word_t'($urandom), 1'b0, 2'd0, 4'b0);
    apply_reset();
    tests++;
    if (bus.empty_o !== 4'b1111) begin
      fails++; $display("FAIL midstream reset empty_o: got %b expected 1111", bus.empty_o);
    end
    run_cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 4'b0);
  endtask

`ifdef MULTI_CHAN_FIFO_FLUSH_EN
  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 5; i++)
      run_cycle(1'b1, 2'd2, word_t'($urandom), 1'b0, 2'd0, 4'b0);
    run_cycle(1'b1, 2'd0, 8'h9C, 1'b0, 2'd0, 4'b0);
    run_cycle(1'b1, 2'd2, 8'hAB, 1'b0, 2'd0, 4'b0100);
    tests++;
    if (bus.empty_o !== 4'b1110) begin
      fails++; $display("FAIL flush empty_o: got %b expected 1110", bus.empty_o);
    end
    run_cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 4'b0);
    run_cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 4'b0);
  endtask
`endif

  initial begin
    bus.w_valid_i = 1'b0;
    bus.w_chan_i  = '0;
    bus.w_data_i  = '0;
    bus.r_req_i   = 1'b0;
    bus.r_chan_i  = '0;
    last_data     = '0;
    last_chan     = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_fill();
    test_full_rw();
    test_wrap();
    test_random();
    test_reset_midstream();
`ifdef MULTI_CHAN_FIFO_FLUSH_EN
    test_flush();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
